// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues word reads to a 1-cycle synchronous imem and buffers
// returned words in a 2-entry skid FIFO presented to decode under valid/ready.
module instr_fetch #(
  parameter int                  PC_WIDTH = 32,
  parameter int                  IMEM_AW  = 10,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_en,
  output logic [IMEM_AW-1:0]  imem_addr,
  input  logic [31:0]         imem_rdata,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [31:0]         instr,
  output logic [PC_WIDTH-1:0] instr_pc,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] inflight_pc;
  logic [1:0]          count;
  logic                inflight;
  logic                kill;
  logic [31:0]         e0_instr, e1_instr;
  logic [PC_WIDTH-1:0] e0_pc, e1_pc;

  logic       pop;
  logic       push;
  logic [2:0] credit;

  assign instr_valid = (count != 2'd0);
  assign pop         = instr_valid & instr_ready & ~redirect_valid;
  assign push        = inflight & ~kill;

  // Slots already claimed by buffered words plus the read on its way back.
  assign credit    = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign imem_en   = rst_n & ~redirect_valid & (credit < 3'd2);
  assign imem_addr = pc[IMEM_AW+1:2];

  assign instr    = instr_valid ? e0_instr : NOP;
  assign instr_pc = instr_valid ? e0_pc : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      inflight_pc <= '0;
      count       <= 2'd0;
      inflight    <= 1'b0;
      kill        <= 1'b0;
      e0_instr    <= '0;
      e1_instr    <= '0;
      e0_pc       <= '0;
      e1_pc       <= '0;
    end else if (redirect_valid) begin
      // Flush buffered words; any read still returning is dropped.
      pc       <= redirect_pc & ~PC_WIDTH'(3);
      count    <= 2'd0;
      inflight <= 1'b0;
      kill     <= inflight;
    end else begin
      inflight <= imem_en;
      kill     <= 1'b0;
      if (imem_en) begin
        pc          <= pc + PC_WIDTH'(4);
        inflight_pc <= pc;
      end
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            e0_instr <= imem_rdata;
            e0_pc    <= inflight_pc;
          end else begin
            e1_instr <= imem_rdata;
            e1_pc    <= inflight_pc;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          e0_instr <= e1_instr;
          e0_pc    <= e1_pc;
          count    <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            e0_instr <= imem_rdata;
            e0_pc    <= inflight_pc;
          end else begin
            e0_instr <= e1_instr;
            e0_pc    <= e1_pc;
            e1_instr <= imem_rdata;
            e1_pc    <= inflight_pc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed cycle table, wrap-around instance, and a random
// ready/redirect run against a stream-level model with mid-stream resets.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_en, imem_en2;
  logic [9:0]  imem_addr, imem_addr2;
  logic [31:0] imem_rdata = '0, imem_rdata2 = '0;
  logic        instr_valid, instr_valid2;
  logic        instr_ready;
  logic [31:0] instr, instr2;
  logic [31:0] instr_pc, instr_pc2;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ready2 = 1'b1;
  logic        rv2 = 1'b0;
  logic [31:0] rpc2 = '0;

  logic [31:0] mem [1024];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instr_fetch #(.PC_WIDTH(32), .IMEM_AW(10), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
  );

  instr_fetch #(.PC_WIDTH(32), .IMEM_AW(10), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .imem_en(imem_en2), .imem_addr(imem_addr2),
    .imem_rdata(imem_rdata2), .instr_valid(instr_valid2), .instr_ready(ready2),
    .instr(instr2), .instr_pc(instr_pc2), .redirect_valid(rv2),
    .redirect_pc(rpc2)
  );

  always @(posedge clk) begin
    if (imem_en)  imem_rdata  <= mem[imem_addr];
    if (imem_en2) imem_rdata2 <= mem[imem_addr2];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return mem[pc[11:2]];
  endfunction

  typedef struct {
    logic        ready;
    logic        rv;
    logic [31:0] rpc;
    logic        v;
    logic [31:0] pc;
    logic        en;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic rv, input logic [31:0] rpc,
                     input logic v, input logic [31:0] pc, input logic en);
    vec_t t;
    t.ready = r; t.rv = rv; t.rpc = rpc; t.v = v; t.pc = pc; t.en = en;
    tbl.push_back(t);
  endtask

  // Drop reset while the stream is live; outputs must clear without waiting for a clock.
  task automatic mid_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_async_instr", instr, NOP);
    chk("rst_async_pc", instr_pc, 32'd0);
    chk("rst_async_en", {31'b0, imem_en}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] exp_pc;
    int          outstanding;
    int          since;
    int          pops;
    logic        exp_v, pop, exp_en;

    for (int i = 0; i < 1024; i++) mem[i] = i;

    // cycle-by-cycle after reset release: stream, 5-cycle stall, redirects
    add(1, 0, 0,      0, 0,      1);  // c0
    add(1, 0, 0,      0, 0,      1);
    add(1, 0, 0,      1, 32'h0,  1);  // c2 first valid
    add(1, 0, 0,      1, 32'h4,  1);
    add(0, 0, 0,      1, 32'h8,  0);  // stall, credits exhausted
    add(0, 0, 0,      1, 32'h8,  0);
    add(0, 0, 0,      1, 32'h8,  0);
    add(0, 0, 0,      1, 32'h8,  0);
    add(0, 0, 0,      1, 32'h8,  0);
    add(1, 0, 0,      1, 32'h8,  1);  // c9 resume
    add(1, 0, 0,      1, 32'hC,  1);
    add(1, 0, 0,      1, 32'h10, 1);
    add(1, 0, 0,      1, 32'h14, 1);
    add(1, 1, 32'h103,1, 32'h18, 0);  // c13 redirect, read in flight
    add(1, 0, 0,      0, 0,      1);
    add(1, 0, 0,      0, 0,      1);
    add(1, 0, 0,      1, 32'h100,1);
    add(1, 0, 0,      1, 32'h104,1);
    add(1, 1, 32'h40, 1, 32'h108,0);  // c18 back-to-back redirects
    add(1, 1, 32'h80, 0, 0,      0);
    add(1, 0, 0,      0, 0,      1);
    add(1, 0, 0,      0, 0,      1);
    add(1, 0, 0,      1, 32'h80, 1);
    add(1, 0, 0,      1, 32'h84, 1);
    add(0, 0, 0,      1, 32'h88, 0);  // fill FIFO
    add(0, 0, 0,      1, 32'h88, 0);
    add(1, 1, 32'h100,1, 32'h88, 0);  // c26 redirect with FIFO full
    add(1, 0, 0,      0, 0,      1);
    add(1, 0, 0,      0, 0,      1);
    add(1, 0, 0,      1, 32'h100,1);
    add(1, 0, 0,      1, 32'h104,1);

    rst_n = 1'b0; instr_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", {31'b0, instr_valid}, 32'd0);
    chk("reset_instr", instr, NOP);
    chk("reset_pc", instr_pc, 32'd0);
    chk("reset_en", {31'b0, imem_en}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      instr_ready = tbl[i].ready;
      redirect_valid = tbl[i].rv;
      redirect_pc = tbl[i].rpc;
      #1;
      chk($sformatf("tbl%0d_valid", i), {31'b0, instr_valid}, {31'b0, tbl[i].v});
      chk($sformatf("tbl%0d_pc", i), instr_pc, tbl[i].pc);
      chk($sformatf("tbl%0d_instr", i), instr, tbl[i].v ? word_at(tbl[i].pc) : NOP);
      chk($sformatf("tbl%0d_en", i), {31'b0, imem_en}, {31'b0, tbl[i].en});
      if (i >= 2 && i <= 4) begin
        chk($sformatf("wrap%0d_valid", i), {31'b0, instr_valid2}, 32'd1);
        chk($sformatf("wrap%0d_pc", i), instr_pc2, 32'hFFFF_FFF8 + 32'(4 * (i - 2)));
        chk($sformatf("wrap%0d_instr", i), instr2, word_at(32'hFFFF_FFF8 + 32'(4 * (i - 2))));
      end
      @(posedge clk); #1;
    end

    // random run; model tracks next expected PC, outstanding reads and flush age
    mid_reset();
    exp_pc = 32'h0; outstanding = 0; since = 1; pops = 0;
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        mid_reset();
        exp_pc = 32'h0; outstanding = 0; since = 1;
      end else begin
        instr_ready    = ($urandom_range(0, 3) != 0);
        redirect_valid = ($urandom_range(0, 11) == 0);
        redirect_pc    = $urandom;
        #1;
        exp_v = (since >= 3);
        chk("rnd_valid", {31'b0, instr_valid}, {31'b0, exp_v});
        if (exp_v) begin
          chk("rnd_pc", instr_pc, exp_pc);
          chk("rnd_instr", instr, word_at(exp_pc));
        end else begin
          chk("rnd_idle_pc", instr_pc, 32'd0);
          chk("rnd_idle_instr", instr, NOP);
        end
        pop    = exp_v & instr_ready & ~redirect_valid;
        exp_en = ~redirect_valid && (outstanding - int'(pop) < 2);
        chk("rnd_en", {31'b0, imem_en}, {31'b0, exp_en});
        if (redirect_valid) begin
          exp_pc = redirect_pc & ~32'd3;
          outstanding = 0;
          since = 1;
        end else begin
          if (pop) begin
            exp_pc = exp_pc + 32'd4;
            pops++;
          end
          outstanding = outstanding + int'(imem_en) - int'(pop);
          chk("rnd_no_overflow", {31'b0, outstanding <= 2}, 32'd1);
          if (since < 3) since++;
        end
        @(posedge clk); #1;
      end
    end
    chk("rnd_progress", {31'b0, pops >= 150}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
